// File: rtl/comb_result_row_mem.sv
// comb_result_row_mem: buffer of FEATURE_ROWS x WEIGHT_COLS dot-product results.
// A start pulse opens a fill pass. Each element is written, optionally
// accumulated, and closed with a final write. Once every element is complete
// the buffer reports done. Rows are read combinationally by the argmax consumer.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start          clears the buffer and opens a fill pass
//   wr_en          element write strobe
//   wr_row/wr_col  element write indices
//   wr_data        two's-complement element value
//   wr_accumulate  1 = add wr_data to the stored entry, 0 = overwrite it
//   wr_final       marks the written entry complete
//   read_row_index row select for rd_row_data
//   rd_row_data    selected row; combinational, zeros for an out-of-range row
//   done_comb      every entry is complete (FULL)
//   busy           fill pass active (FILL)
//   wr_error       sticky flag for an ignored write; cleared by start
//
// Configuration macro COMB_MEM_SATURATE_EN: when defined, accumulation
// saturates to the signed extremes. The default build wraps modulo 2^width.
module comb_result_row_mem #(
    parameter int unsigned FEATURE_ROWS   = 6,
    parameter int unsigned WEIGHT_COLS    = 3,
    parameter int unsigned DOT_PROD_WIDTH = 16,
    parameter int unsigned ROW_IDX_WIDTH  = 3,
    parameter int unsigned COL_IDX_WIDTH  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      wr_en,
    input  logic [ROW_IDX_WIDTH-1:0]  wr_row,
    input  logic [COL_IDX_WIDTH-1:0]  wr_col,
    input  logic [DOT_PROD_WIDTH-1:0] wr_data,
    input  logic                      wr_accumulate,
    input  logic                      wr_final,
    input  logic [WEIGHT_COLS-1:0]    read_row_index,
    output logic [DOT_PROD_WIDTH-1:0] rd_row_data [0:WEIGHT_COLS-1],
    output logic                      done_comb,
    output logic                      busy,
    output logic                      wr_error
);

    localparam int unsigned W = DOT_PROD_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0] mem      [FEATURE_ROWS][WEIGHT_COLS];
    logic         complete [FEATURE_ROWS][WEIGHT_COLS];

    logic         all_complete;
    logic         in_range;
    logic         sel_complete;
    logic [W-1:0] sel_value;
    logic [W-1:0] acc_value;
    logic [W-1:0] new_value;
    logic         wr_accept;
    logic         wr_illegal;

    // All entries complete.
    always_comb begin
        all_complete = 1'b1;
        for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
            for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
                all_complete = all_complete & complete[r][c];
            end
        end
    end

    // Select the addressed entry; out-of-range indices match nothing.
    always_comb begin
        sel_complete = 1'b0;
        sel_value    = '0;
        for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
            for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
                if (wr_row == ROW_IDX_WIDTH'(r) && wr_col == COL_IDX_WIDTH'(c)) begin
                    sel_complete = complete[r][c];
                    sel_value    = mem[r][c];
                end
            end
        end
    end

    assign in_range = (32'(wr_row) < FEATURE_ROWS) && (32'(wr_col) < WEIGHT_COLS);

    // start takes priority; any write in the same cycle is simply dropped.
    assign wr_accept  = wr_en && !start && (state == FILL) && in_range && !sel_complete;
    assign wr_illegal = wr_en && !start && !wr_accept;

`ifdef COMB_MEM_SATURATE_EN
    // Saturating accumulate: sign-extend by one bit and clamp on overflow.
    logic [W:0] sum_ext;
    always_comb begin
        sum_ext = {sel_value[W-1], sel_value} + {wr_data[W-1], wr_data};
        if (sum_ext[W] != sum_ext[W-1]) begin
            acc_value = sum_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            acc_value = sum_ext[W-1:0];
        end
    end
`else
    // Wrapping accumulate: plain modulo-2^W addition.
    assign acc_value = sel_value + wr_data;
`endif

    assign new_value = wr_accumulate ? acc_value : wr_data;

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = FILL;
            FILL: begin
                if (start) begin
                    state_next = FILL;
                end else if (all_complete) begin
                    state_next = FULL;
                end
            end
            FULL: if (start) state_next = FILL;
            default: state_next = IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            done_comb <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            done_comb <= (state_next == FULL);
            busy      <= (state_next == FILL);
        end
    end

    // Entry storage and complete bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
                for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
                    mem[r][c]      <= '0;
                    complete[r][c] <= 1'b0;
                end
            end
        end else if (start) begin
            for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
                for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
                    mem[r][c]      <= '0;
                    complete[r][c] <= 1'b0;
                end
            end
        end else if (wr_accept) begin
            for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
                for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
                    if (wr_row == ROW_IDX_WIDTH'(r) && wr_col == COL_IDX_WIDTH'(c)) begin
                        mem[r][c] <= new_value;
                        if (wr_final) begin
                            complete[r][c] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Sticky illegal-write flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_error <= 1'b0;
        end else if (start) begin
            wr_error <= 1'b0;
        end else if (wr_illegal) begin
            wr_error <= 1'b1;
        end
    end

    // Zero-latency row read; an unmatched index returns zeros.
    always_comb begin
        for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
            rd_row_data[c] = '0;
            for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
                if (read_row_index == WEIGHT_COLS'(r)) begin
                    rd_row_data[c] = mem[r][c];
                end
            end
        end
    end

endmodule

// File: tb/tb_comb_result_row_mem.sv
// Self-checking bench for comb_result_row_mem: directed sequences, a vector
// table and randomized traffic checked against a behavioural model.
module tb_comb_result_row_mem;

    localparam int ROWS = 6;
    localparam int COLS = 3;

    logic        clk;
    logic        reset;
    logic        start;
    logic        wr_en;
    logic [2:0]  wr_row;
    logic [1:0]  wr_col;
    logic [15:0] wr_data;
    logic        wr_accumulate;
    logic        wr_final;
    logic [2:0]  read_row_index;
    logic [15:0] rd_row_data [0:2];
    logic        done_comb;
    logic        busy;
    logic        wr_error;

    comb_result_row_mem dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .wr_en          (wr_en),
        .wr_row         (wr_row),
        .wr_col         (wr_col),
        .wr_data        (wr_data),
        .wr_accumulate  (wr_accumulate),
        .wr_final       (wr_final),
        .read_row_index (read_row_index),
        .rd_row_data    (rd_row_data),
        .done_comb      (done_comb),
        .busy           (busy),
        .wr_error       (wr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase 0 = idle, 1 = filling, 2 = full.
    int m_mem [ROWS][COLS];
    bit m_cmp [ROWS][COLS];
    int m_phase;
    bit m_err;

    function automatic logic [15:0] to16(input int v);
        return 16'(v);
    endfunction

    function automatic int acc_model(input int a, input int d);
        int s;
        s = a + d;
`ifdef COMB_MEM_SATURATE_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
`else
        return int'(shortint'(s));
`endif
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                m_mem[r][c] = 0;
                m_cmp[r][c] = 1'b0;
            end
    endtask

    // Apply one clock edge of the model from the current inputs.
    task automatic model_edge();
        bit all;
        int nphase;
        int r;
        int c;
        if (start) begin
            model_clear();
            m_phase = 1;
            m_err   = 1'b0;
            return;
        end
        all = 1'b1;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                all &= m_cmp[i][j];
        nphase = (m_phase == 1 && all) ? 2 : m_phase;
        if (wr_en) begin
            r = int'(wr_row);
            c = int'(wr_col);
            if (m_phase != 1 || r >= ROWS || c >= COLS) begin
                m_err = 1'b1;
            end else if (m_cmp[r][c]) begin
                m_err = 1'b1;
            end else begin
                m_mem[r][c] = wr_accumulate ? acc_model(m_mem[r][c], int'($signed(wr_data)))
                                            : int'($signed(wr_data));
                if (wr_final) m_cmp[r][c] = 1'b1;
            end
        end
        m_phase = nphase;
    endtask

    task automatic check_read(input string name);
        int idx;
        idx = int'(read_row_index);
        for (int c = 0; c < COLS; c++)
            chk(name, int'(rd_row_data[c]), int'(idx < ROWS ? to16(m_mem[idx][c]) : 16'h0));
    endtask

    task automatic check_all(input string name);
        chk({name, "_done"}, int'(done_comb), int'(m_phase == 2));
        chk({name, "_busy"}, int'(busy), int'(m_phase == 1));
        chk({name, "_err"}, int'(wr_error), int'(m_err));
        check_read({name, "_rd"});
    endtask

    task automatic idle_inputs();
        start = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        wr_accumulate = 1'b0; wr_final = 1'b0;
    endtask

    task automatic set_wr(input int r, input int c, input int d, input bit acc, input bit fin);
        wr_en = 1'b1; wr_row = 3'(r); wr_col = 2'(c); wr_data = 16'(d);
        wr_accumulate = acc; wr_final = fin;
    endtask

    // One cycle: pre-edge read (old data), model update, post-edge compare.
    task automatic tick(input string name);
        #1;
        check_read({name, "_pre"});
        model_edge();
        @(posedge clk);
        #1;
        check_all(name);
    endtask

    task automatic do_start();
        idle_inputs();
        start = 1'b1;
        tick("start");
        start = 1'b0;
    endtask

    typedef struct {
        bit start;
        bit wr_en;
        int row;
        int col;
        int data;
        bit acc;
        bit fin;
        int rd_idx;
        bit exp_busy;
        bit exp_done;
        bit exp_err;
        int exp_rd [3];
    } vec_t;

    function automatic vec_t mk(input bit s, input bit we, input int r, input int c, input int d,
                                input bit acc, input bit fin, input int ri, input bit eb,
                                input bit ed, input bit ee, input int e0, input int e1, input int e2);
        vec_t v;
        v.start = s; v.wr_en = we; v.row = r; v.col = c; v.data = d; v.acc = acc; v.fin = fin;
        v.rd_idx = ri; v.exp_busy = eb; v.exp_done = ed; v.exp_err = ee;
        v.exp_rd[0] = e0; v.exp_rd[1] = e1; v.exp_rd[2] = e2;
        return v;
    endfunction

    vec_t vecs [10];
    int   order [18];

    initial begin
        vecs[0] = mk(0, 1, 2, 1, 100, 0, 0, 2, 1, 0, 0, 0, 100, 0);
        vecs[1] = mk(0, 1, 2, 1, 23, 1, 1, 2, 1, 0, 0, 0, 123, 0);
        vecs[2] = mk(0, 1, 2, 1, 5, 0, 0, 2, 1, 0, 1, 0, 123, 0);
        vecs[3] = mk(1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        vecs[4] = mk(0, 1, 6, 0, 9, 0, 1, 6, 1, 0, 1, 0, 0, 0);
        vecs[5] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[6] = mk(0, 1, 0, 3, 9, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        vecs[7] = mk(0, 1, 0, 0, -5, 0, 0, 0, 1, 0, 1, -5, 0, 0);
        vecs[8] = mk(0, 1, 0, 0, 7, 1, 1, 0, 1, 0, 1, 2, 0, 0);
        vecs[9] = mk(0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0);

        idle_inputs();
        read_row_index = 3'd0;
        m_phase = 0;
        m_err   = 1'b0;
        model_clear();

        // Reset state, including reads while reset is held.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", int'(done_comb), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(wr_error), 0);
        for (int i = 0; i < 8; i++) begin
            read_row_index = 3'(i);
            #1;
            for (int c = 0; c < COLS; c++) chk("rst_rd", int'(rd_row_data[c]), 0);
        end
        reset = 1'b0;
        read_row_index = 3'd0;
        tick("post_rst");

        // Full pass in shuffled order with value row*10+col.
        do_start();
        for (int i = 0; i < 18; i++) order[i] = i;
        for (int i = 17; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        read_row_index = 3'd4;
        for (int i = 0; i < 18; i++) begin
            set_wr(order[i] / 3, order[i] % 3, (order[i] / 3) * 10 + order[i] % 3, 0, 1);
            tick("fill");
        end
        chk("fill_done_not_yet", int'(done_comb), 0);
        idle_inputs();
        tick("fill_settle");
        chk("fill_done", int'(done_comb), 1);
        chk("fill_busy", int'(busy), 0);
        chk("row4_c0", int'(rd_row_data[0]), 40);
        chk("row4_c1", int'(rd_row_data[1]), 41);
        chk("row4_c2", int'(rd_row_data[2]), 42);

        // Write in FULL flags an error; start with a write drops the write.
        set_wr(0, 0, 77, 0, 1);
        tick("full_write");
        chk("full_write_err", int'(wr_error), 1);
        set_wr(1, 1, 55, 0, 1);
        start = 1'b1;
        read_row_index = 3'd1;
        tick("restart");
        chk("restart_busy", int'(busy), 1);
        chk("restart_done", int'(done_comb), 0);
        chk("restart_zero", int'(rd_row_data[1]), 0);
        chk("restart_err", int'(wr_error), 0);

        // Table-driven vectors starting in FILL.
        do_start();
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            start = vecs[i].start;
            if (vecs[i].wr_en)
                set_wr(vecs[i].row, vecs[i].col, vecs[i].data, vecs[i].acc, vecs[i].fin);
            read_row_index = 3'(vecs[i].rd_idx);
            tick("vec");
            chk("vec_busy", int'(busy), int'(vecs[i].exp_busy));
            chk("vec_done", int'(done_comb), int'(vecs[i].exp_done));
            chk("vec_err", int'(wr_error), int'(vecs[i].exp_err));
            for (int c = 0; c < COLS; c++)
                chk("vec_rd", int'(rd_row_data[c]), int'(to16(vecs[i].exp_rd[c])));
        end

        // Accumulate overflow at the positive extreme.
        do_start();
        read_row_index = 3'd0;
        set_wr(0, 0, 32767, 0, 0);
        tick("ovf_load");
        set_wr(0, 0, 1, 1, 0);
        tick("ovf_acc");
`ifdef COMB_MEM_SATURATE_EN
        chk("ovf_result", int'(rd_row_data[0]), 32767);
`else
        chk("ovf_result", int'(rd_row_data[0]), 32768);
`endif
        chk("ovf_err", int'(wr_error), 0);

        // Asynchronous reset mid-fill after 10 writes.
        do_start();
        for (int i = 0; i < 10; i++) begin
            set_wr(i / 3, i % 3, 1000 + i, 0, 1);
            tick("pre_rst_fill");
        end
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        m_phase = 0;
        m_err   = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done_comb), 0);
        for (int i = 0; i < ROWS; i++) begin
            read_row_index = 3'(i);
            #1;
            for (int c = 0; c < COLS; c++) chk("midrst_rd", int'(rd_row_data[c]), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_wr(1, 1, 5, 0, 1);
        tick("idle_write");
        chk("idle_write_err", int'(wr_error), 1);
        chk("idle_write_busy", int'(busy), 0);

        // Randomized traffic against the model.
        do_start();
        for (int n = 0; n < 800; n++) begin
            idle_inputs();
            start = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) != 0)
                set_wr(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 65535)) - 32768,
                       1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 7) == 0) wr_data = ($urandom_range(0, 1) != 0) ? 16'h7fff : 16'h8000;
            read_row_index = 3'($urandom_range(0, 7));
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
